hack_wr_trace_fifo: RTL and testbench
=====================================

Name: hack_wr_trace_fifo

Overview:
- Downstream observer of the Hack CPU core's data-memory write port (write enable, RAM address, CPU data out).
- Timestamps every qualifying RAM write and buffers it in a FIFO.
- Buffered entries drain through a valid/ready port to a trace sink (UART or log bridge), so write traces can be compared against the golden write log on silicon, not just in simulation.

Parameters:
- ADDR_W, 15, RAM address width (Hack data space).
- DATA_W, 16, write data width.
- TS_W, 16, cycle-stamp width.
- DEPTH, 16, FIFO entries; power of 2, at least 2.
- FILT_LO, 15'h0000, lowest captured address, inclusive.
- FILT_HI, 15'h7FFF, highest captured address, inclusive.

Ports:
- Clk  input  1  core clock; all logic on its rising edge.
- Reset  input  1  synchronous, active-low reset.
- CaptureEn  input  1  1 = qualifying writes are captured.
- WrEn  input  1  CPU RAM write enable.
- WrAddr  input  ADDR_W  CPU RAM address.
- WrData  input  DATA_W  CPU data out.
- OutValid  output  1  head entry available.
- OutReady  input  1  sink accepts the head entry.
- OutAddr  output  ADDR_W  head entry address.
- OutData  output  DATA_W  head entry data.
- OutStamp  output  TS_W  head entry cycle stamp.
- Count  output  $clog2(DEPTH)+1  current occupancy.
- Overflow  output  1  sticky; set when a qualifying write was dropped.
- DropCnt  output  8  dropped writes; saturates at 255.
- ClrOvf  input  1  clears Overflow and DropCnt.

Behaviour:
- Reset (Reset=0 at a rising edge):
  - Pointers, Count, stamp counter, Overflow and DropCnt go to 0.
  - OutValid=0; OutAddr, OutData and OutStamp = 0.
  - Reset mid-operation discards all stored entries.
- Stamp counter:
  - Free-running, +1 every cycle out of reset, wraps 2^TS_W-1 -> 0.
  - The first cycle after reset release has stamp 0.
- Qualify condition: CaptureEn & WrEn & (FILT_LO <= WrAddr <= FILT_HI).
- Push:
  - On a qualifying edge, {WrAddr, WrData, stamp-of-that-cycle} is written at the write pointer.
  - The write pointer advances modulo DEPTH.
- Pop:
  - Occurs on an edge where OutValid & OutReady; the read pointer advances.
  - OutReady while OutValid=0 has no effect.
- Latency: an entry pushed at edge N is visible with OutValid=1 after edge N. There is no same-cycle bypass, even when the FIFO is empty.
- Outputs:
  - OutAddr, OutData and OutStamp show the head entry while OutValid=1.
  - They are forced to 0 while OutValid=0.
  - They are stable while OutValid=1 and OutReady=0.
- Count:
  - Push only: +1. Pop only: -1. Push and pop together: unchanged.
  - OutValid = (Count != 0).
- Full (Count = DEPTH):
  - Qualifying write with no pop in the same cycle: dropped; Overflow<=1; DropCnt<=DropCnt+1, saturating.
  - Qualifying write with a pop in the same cycle: accepted, no drop; Count stays DEPTH.
- ClrOvf:
  - Overflow<=0 and DropCnt<=0.
  - If a drop occurs in the same cycle, the drop wins: Overflow=1, DropCnt=1.
- Empty: a pop is impossible; a push and a sink-ready in the same cycle pushes only.
- Wrap-around: pointers wrap modulo DEPTH; ordering is strictly FIFO across wraps.
- CaptureEn deassert: stops new captures only; stored entries continue to drain.

Test Plan:
- Reset release, then WrEn=1, WrAddr=15'h0010, WrData=16'h1234 at stamp 5, OutReady=0 -> next cycle OutValid=1, OutAddr=0010, OutData=1234, OutStamp=0005, Count=1.
- 20 back-to-back qualifying writes (addr 0..19, data = addr+16'h100), OutReady=0 -> Count=16, Overflow=1, DropCnt=4. Drain then yields addr 0..15 in order with consecutive stamps.
- FIFO full, qualifying write with OutReady=1 in the same cycle -> no drop, Count=16, Overflow stays 0, head advances by one.
- FILT_LO=15'h4000, FILT_HI=15'h5FFF; writes to 3FFF, 4000, 5FFF, 6000 -> only 4000 and 5FFF are captured, Count=2.
- TS_W=4; write at cycle 15 and cycle 16 -> stamps 4'hF then 4'h0.
- Overflowed FIFO with DropCnt=3; ClrOvf=1 and a drop in the same cycle -> Overflow=1, DropCnt=1. Then Reset=0 for one cycle mid-drain -> Count=0, OutValid=0, all outputs 0.

Source files
------------

// File: rtl/hack_wr_trace_fifo.sv
// hack_wr_trace_fifo
// Observes the Hack CPU data-memory write port, stamps every qualifying RAM
// write with a free-running cycle counter and buffers {address, data, stamp}
// in a FIFO that drains through a valid/ready port to a trace sink.
//
// Ports:
//   Clk        core clock, all logic on its rising edge
//   Reset      synchronous active-low reset
//   CaptureEn  1 = qualifying writes are captured
//   WrEn       CPU RAM write enable
//   WrAddr     CPU RAM address
//   WrData     CPU data out
//   OutValid   head entry available
//   OutReady   sink accepts the head entry
//   OutAddr    head entry address (0 while OutValid=0)
//   OutData    head entry data    (0 while OutValid=0)
//   OutStamp   head entry stamp   (0 while OutValid=0)
//   Count      current occupancy
//   Overflow   sticky, a qualifying write was dropped
//   DropCnt    dropped writes, saturating at 255
//   ClrOvf     clears Overflow and DropCnt (a same-cycle drop wins)
module hack_wr_trace_fifo #(
  parameter int                ADDR_W  = 15,
  parameter int                DATA_W  = 16,
  parameter int                TS_W    = 16,
  parameter int                DEPTH   = 16,
  parameter logic [ADDR_W-1:0] FILT_LO = 15'h0000,
  parameter logic [ADDR_W-1:0] FILT_HI = 15'h7FFF
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic                     CaptureEn,
  input  logic                     WrEn,
  input  logic [ADDR_W-1:0]        WrAddr,
  input  logic [DATA_W-1:0]        WrData,
  output logic                     OutValid,
  input  logic                     OutReady,
  output logic [ADDR_W-1:0]        OutAddr,
  output logic [DATA_W-1:0]        OutData,
  output logic [TS_W-1:0]          OutStamp,
  output logic [$clog2(DEPTH):0]   Count,
  output logic                     Overflow,
  output logic [7:0]               DropCnt,
  input  logic                     ClrOvf
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [PTR_W-1:0] PTR_ONE  = {{(PTR_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [TS_W-1:0]  TS_ONE   = {{(TS_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  // Entry storage (no reset needed: occupancy decides what is valid)
  logic [ADDR_W-1:0] mem_addr_r  [DEPTH];
  logic [DATA_W-1:0] mem_data_r  [DEPTH];
  logic [TS_W-1:0]   mem_stamp_r [DEPTH];

  logic [PTR_W-1:0]  wr_ptr_r;
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [CNT_W-1:0]  count_r;
  logic [TS_W-1:0]   stamp_r;
  logic              valid_r;
  logic [ADDR_W-1:0] out_addr_r;
  logic [DATA_W-1:0] out_data_r;
  logic [TS_W-1:0]   out_stamp_r;
  logic              ovf_r;
  logic [7:0]        drop_cnt_r;

  logic              lo_ok_s;
  logic              hi_ok_s;
  logic              qualify_s;
  logic              pop_s;
  logic              full_s;
  logic              drop_s;
  logic              push_s;
  logic [CNT_W-1:0]  count_nxt_s;
  logic [PTR_W-1:0]  rd_ptr_nxt_s;
  logic [ADDR_W-1:0] head_addr_s;
  logic [DATA_W-1:0] head_data_s;
  logic [TS_W-1:0]   head_stamp_s;
  logic              ovf_nxt_s;
  logic [7:0]        drop_cnt_nxt_s;

  // Address window check; the extra MSB keeps the compare meaningful at the
  // extreme window limits (0 and all-ones).
  assign lo_ok_s = ({1'b1, WrAddr} >= {1'b1, FILT_LO});
  assign hi_ok_s = ({1'b0, WrAddr} <= {1'b0, FILT_HI});

  // Push/pop/drop qualification for this edge
  always_comb begin
    qualify_s = CaptureEn & WrEn & lo_ok_s & hi_ok_s;
    pop_s     = valid_r & OutReady;
    full_s    = (count_r == FULL_CNT);
    // A full FIFO still accepts a write when the head leaves in the same cycle
    drop_s    = qualify_s & full_s & ~pop_s;
    push_s    = qualify_s & ~drop_s;
  end

  // Next occupancy and next read pointer
  always_comb begin
    count_nxt_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_nxt_s = count_r + CNT_ONE;
      2'b01:   count_nxt_s = count_r - CNT_ONE;
      default: count_nxt_s = count_r;
    endcase
    if (pop_s) begin
      rd_ptr_nxt_s = rd_ptr_r + PTR_ONE;
    end else begin
      rd_ptr_nxt_s = rd_ptr_r;
    end
  end

  // Next head entry, so the output port can be registered. When the next
  // head is the slot being written this edge (empty FIFO, or the last entry
  // leaving while a new one arrives) it comes from the write port instead.
  always_comb begin
    head_addr_s  = {ADDR_W{1'b0}};
    head_data_s  = {DATA_W{1'b0}};
    head_stamp_s = {TS_W{1'b0}};
    if (count_nxt_s == CNT_ZERO) begin
      head_addr_s  = {ADDR_W{1'b0}};
      head_data_s  = {DATA_W{1'b0}};
      head_stamp_s = {TS_W{1'b0}};
    end else if (push_s && (wr_ptr_r == rd_ptr_nxt_s)) begin
      head_addr_s  = WrAddr;
      head_data_s  = WrData;
      head_stamp_s = stamp_r;
    end else begin
      head_addr_s  = mem_addr_r[rd_ptr_nxt_s];
      head_data_s  = mem_data_r[rd_ptr_nxt_s];
      head_stamp_s = mem_stamp_r[rd_ptr_nxt_s];
    end
  end

  // Sticky overflow and saturating drop counter; a drop beats a clear
  always_comb begin
    ovf_nxt_s      = ovf_r;
    drop_cnt_nxt_s = drop_cnt_r;
    if (drop_s) begin
      ovf_nxt_s = 1'b1;
      if (ClrOvf) begin
        drop_cnt_nxt_s = 8'd1;
      end else if (drop_cnt_r == 8'hFF) begin
        drop_cnt_nxt_s = 8'hFF;
      end else begin
        drop_cnt_nxt_s = drop_cnt_r + 8'd1;
      end
    end else if (ClrOvf) begin
      ovf_nxt_s      = 1'b0;
      drop_cnt_nxt_s = 8'd0;
    end else begin
      ovf_nxt_s      = ovf_r;
      drop_cnt_nxt_s = drop_cnt_r;
    end
  end

  // Entry storage write
  always_ff @(posedge Clk) begin
    if (Reset && push_s) begin
      mem_addr_r[wr_ptr_r]  <= WrAddr;
      mem_data_r[wr_ptr_r]  <= WrData;
      mem_stamp_r[wr_ptr_r] <= stamp_r;
    end
  end

  // Control state, stamp counter and registered output port
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      wr_ptr_r    <= {PTR_W{1'b0}};
      rd_ptr_r    <= {PTR_W{1'b0}};
      count_r     <= CNT_ZERO;
      stamp_r     <= {TS_W{1'b0}};
      valid_r     <= 1'b0;
      out_addr_r  <= {ADDR_W{1'b0}};
      out_data_r  <= {DATA_W{1'b0}};
      out_stamp_r <= {TS_W{1'b0}};
      ovf_r       <= 1'b0;
      drop_cnt_r  <= 8'd0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      rd_ptr_r    <= rd_ptr_nxt_s;
      count_r     <= count_nxt_s;
      stamp_r     <= stamp_r + TS_ONE;
      valid_r     <= (count_nxt_s != CNT_ZERO);
      out_addr_r  <= head_addr_s;
      out_data_r  <= head_data_s;
      out_stamp_r <= head_stamp_s;
      ovf_r       <= ovf_nxt_s;
      drop_cnt_r  <= drop_cnt_nxt_s;
    end
  end

  assign OutValid = valid_r;
  assign OutAddr  = out_addr_r;
  assign OutData  = out_data_r;
  assign OutStamp = out_stamp_r;
  assign Count    = count_r;
  assign Overflow = ovf_r;
  assign DropCnt  = drop_cnt_r;

endmodule

// File: tb/tb_hack_wr_trace_fifo.sv
// Testbench for hack_wr_trace_fifo: directed scenarios plus a randomized run
// checked against a queue-based reference model of the default instance.
// Two extra instances cover the address window and a narrow stamp width.
module tb_hack_wr_trace_fifo;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        CaptureEn;
  logic        WrEn;
  logic [14:0] WrAddr;
  logic [15:0] WrData;
  logic        OutReady;
  logic        ClrOvf;

  logic        OutValid;
  logic [14:0] OutAddr;
  logic [15:0] OutData;
  logic [15:0] OutStamp;
  logic [4:0]  Count;
  logic        Overflow;
  logic [7:0]  DropCnt;

  logic        f_valid;
  logic [14:0] f_addr;
  logic [15:0] f_data;
  logic [15:0] f_stamp;
  logic [4:0]  f_count;
  logic        f_ovf;
  logic [7:0]  f_drop;

  logic        t_valid;
  logic [14:0] t_addr;
  logic [15:0] t_data;
  logic [3:0]  t_stamp;
  logic [4:0]  t_count;
  logic        t_ovf;
  logic [7:0]  t_drop;

  int checks = 0;
  int errors = 0;

  always #5 Clk = ~Clk;

  hack_wr_trace_fifo dut (
    .Clk(Clk), .Reset(Reset), .CaptureEn(CaptureEn), .WrEn(WrEn),
    .WrAddr(WrAddr), .WrData(WrData), .OutValid(OutValid), .OutReady(OutReady),
    .OutAddr(OutAddr), .OutData(OutData), .OutStamp(OutStamp), .Count(Count),
    .Overflow(Overflow), .DropCnt(DropCnt), .ClrOvf(ClrOvf)
  );

  hack_wr_trace_fifo #(.FILT_LO(15'h4000), .FILT_HI(15'h5FFF)) dut_filt (
    .Clk(Clk), .Reset(Reset), .CaptureEn(CaptureEn), .WrEn(WrEn),
    .WrAddr(WrAddr), .WrData(WrData), .OutValid(f_valid), .OutReady(OutReady),
    .OutAddr(f_addr), .OutData(f_data), .OutStamp(f_stamp), .Count(f_count),
    .Overflow(f_ovf), .DropCnt(f_drop), .ClrOvf(ClrOvf)
  );

  hack_wr_trace_fifo #(.TS_W(4)) dut_ts (
    .Clk(Clk), .Reset(Reset), .CaptureEn(CaptureEn), .WrEn(WrEn),
    .WrAddr(WrAddr), .WrData(WrData), .OutValid(t_valid), .OutReady(OutReady),
    .OutAddr(t_addr), .OutData(t_data), .OutStamp(t_stamp), .Count(t_count),
    .Overflow(t_ovf), .DropCnt(t_drop), .ClrOvf(ClrOvf)
  );

  // Reference model of the default instance: a queue of entries plus counters
  typedef struct packed {
    logic [14:0] a;
    logic [15:0] d;
    logic [15:0] s;
  } ent_t;

  ent_t        mq[$];
  int unsigned m_cyc  = 0;
  bit          m_ovf  = 1'b0;
  int          m_drop = 0;

  logic [61:0] dut_view;
  assign dut_view = {OutValid, OutAddr, OutData, OutStamp, Count, Overflow, DropCnt};

  function automatic logic [61:0] model_view();
    ent_t h;
    h = '0;
    if (mq.size() != 0) h = mq[0];
    return {mq.size() != 0, h.a, h.d, h.s, 5'(mq.size()), m_ovf, 8'(m_drop)};
  endfunction

  // Apply the current inputs to the model, as the coming rising edge will
  task automatic model_step();
    bit pop, qual, drop;
    if (!Reset) begin
      mq.delete();
      m_cyc  = 0;
      m_ovf  = 1'b0;
      m_drop = 0;
    end else begin
      pop  = (mq.size() != 0) && OutReady;
      qual = CaptureEn && WrEn;
      drop = qual && (mq.size() == 16) && !pop;
      if (pop) void'(mq.pop_front());
      if (qual && !drop) mq.push_back({WrAddr, WrData, m_cyc[15:0]});
      if (drop) begin
        m_ovf  = 1'b1;
        m_drop = ClrOvf ? 1 : ((m_drop < 255) ? m_drop + 1 : 255);
      end else if (ClrOvf) begin
        m_ovf  = 1'b0;
        m_drop = 0;
      end
      m_cyc++;
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge Clk);
    @(negedge Clk);
  endtask

  task automatic idle_inputs();
    CaptureEn = 1'b1;
    WrEn      = 1'b0;
    WrAddr    = 15'h0000;
    WrData    = 16'h0000;
    OutReady  = 1'b0;
    ClrOvf    = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    Reset = 1'b0;
    tick();
    tick();
    Reset = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    Reset = 1'b0;
    tick();
    tick();
    checks++;
    if (dut_view !== 62'd0) begin
      errors++;
      $display("FAIL reset_main: got %h expected %h", dut_view, 62'd0);
    end
    checks++;
    if ({f_valid, f_addr, f_data, f_stamp, f_count, f_ovf, f_drop} !== 62'd0 ||
        {t_valid, t_addr, t_data, t_stamp, t_count, t_ovf, t_drop} !== 50'd0) begin
      errors++;
      $display("FAIL reset_variants: got filt=%h ts=%h expected 0",
               {f_valid, f_addr, f_data, f_stamp, f_count, f_ovf, f_drop},
               {t_valid, t_addr, t_data, t_stamp, t_count, t_ovf, t_drop});
    end
    Reset = 1'b1;
  endtask

  task automatic test_first_write();
    do_reset();
    repeat (5) tick();
    WrEn   = 1'b1;
    WrAddr = 15'h0010;
    WrData = 16'h1234;
    tick();
    WrEn = 1'b0;
    checks++;
    if ({OutValid, OutAddr, OutData, OutStamp, Count} !==
        {1'b1, 15'h0010, 16'h1234, 16'h0005, 5'd1}) begin
      errors++;
      $display("FAIL first_write: got v=%b a=%h d=%h s=%h c=%0d expected v=1 a=0010 d=1234 s=0005 c=1",
               OutValid, OutAddr, OutData, OutStamp, Count);
    end
  endtask

  task automatic test_overflow();
    int unsigned first;
    do_reset();
    first = m_cyc;
    for (int i = 0; i < 20; i++) begin
      WrEn   = 1'b1;
      WrAddr = 15'(i);
      WrData = 16'(i + 256);
      tick();
    end
    WrEn = 1'b0;
    checks++;
    if ({OutValid, Count, Overflow, DropCnt} !== {1'b1, 5'd16, 1'b1, 8'd4}) begin
      errors++;
      $display("FAIL overflow_state: got v=%b c=%0d ovf=%b drop=%0d expected v=1 c=16 ovf=1 drop=4",
               OutValid, Count, Overflow, DropCnt);
    end
    OutReady = 1'b1;
    for (int i = 0; i < 16; i++) begin
      checks++;
      if ({OutValid, OutAddr, OutData, OutStamp} !==
          {1'b1, 15'(i), 16'(i + 256), 16'(first + i)}) begin
        errors++;
        $display("FAIL drain_order[%0d]: got v=%b a=%h d=%h s=%h expected a=%h d=%h s=%h",
                 i, OutValid, OutAddr, OutData, OutStamp, 15'(i), 16'(i + 256), 16'(first + i));
      end
      tick();
    end
    OutReady = 1'b0;
    checks++;
    if ({OutValid, OutAddr, OutData, OutStamp, Count} !== 53'd0) begin
      errors++;
      $display("FAIL drained_empty: got v=%b a=%h d=%h s=%h c=%0d expected all 0",
               OutValid, OutAddr, OutData, OutStamp, Count);
    end
  endtask

  task automatic test_full_push_pop();
    do_reset();
    for (int i = 0; i < 16; i++) begin
      WrEn   = 1'b1;
      WrAddr = 15'(i);
      WrData = 16'(16'hA000 + i);
      tick();
    end
    WrAddr   = 15'h0100;
    WrData   = 16'hBEEF;
    OutReady = 1'b1;
    tick();
    WrEn     = 1'b0;
    OutReady = 1'b0;
    checks++;
    if ({Count, Overflow, DropCnt, OutAddr, OutData} !==
        {5'd16, 1'b0, 8'd0, 15'd1, 16'hA001}) begin
      errors++;
      $display("FAIL full_push_pop: got c=%0d ovf=%b drop=%0d a=%h d=%h expected c=16 ovf=0 drop=0 a=0001 d=a001",
               Count, Overflow, DropCnt, OutAddr, OutData);
    end
    checks++;
    if (dut_view !== model_view()) begin
      errors++;
      $display("FAIL full_push_pop_model: got %h expected %h", dut_view, model_view());
    end
  endtask

  task automatic test_filter();
    logic [14:0] addrs [4];
    addrs[0] = 15'h3FFF;
    addrs[1] = 15'h4000;
    addrs[2] = 15'h5FFF;
    addrs[3] = 15'h6000;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      WrEn   = 1'b1;
      WrAddr = addrs[i];
      WrData = 16'(16'h0C00 + i);
      tick();
    end
    WrEn = 1'b0;
    checks++;
    if ({f_valid, f_count, f_addr, f_data} !== {1'b1, 5'd2, 15'h4000, 16'h0C01}) begin
      errors++;
      $display("FAIL filter_capture: got v=%b c=%0d a=%h d=%h expected v=1 c=2 a=4000 d=0c01",
               f_valid, f_count, f_addr, f_data);
    end
    OutReady = 1'b1;
    tick();
    OutReady = 1'b0;
    checks++;
    if ({f_count, f_addr, f_data} !== {5'd1, 15'h5FFF, 16'h0C02}) begin
      errors++;
      $display("FAIL filter_second: got c=%0d a=%h d=%h expected c=1 a=5fff d=0c02",
               f_count, f_addr, f_data);
    end
    checks++;
    if (dut_view !== model_view()) begin
      errors++;
      $display("FAIL filter_main_model: got %h expected %h", dut_view, model_view());
    end
  endtask

  task automatic test_ts_wrap();
    do_reset();
    repeat (15) tick();
    WrEn   = 1'b1;
    WrAddr = 15'h0007;
    WrData = 16'h1111;
    tick();
    WrAddr = 15'h0008;
    WrData = 16'h2222;
    tick();
    WrEn = 1'b0;
    checks++;
    if ({t_count, t_addr, t_stamp} !== {5'd2, 15'h0007, 4'hF}) begin
      errors++;
      $display("FAIL ts_wrap_first: got c=%0d a=%h s=%h expected c=2 a=0007 s=f",
               t_count, t_addr, t_stamp);
    end
    OutReady = 1'b1;
    tick();
    OutReady = 1'b0;
    checks++;
    if ({t_count, t_addr, t_stamp} !== {5'd1, 15'h0008, 4'h0}) begin
      errors++;
      $display("FAIL ts_wrap_second: got c=%0d a=%h s=%h expected c=1 a=0008 s=0",
               t_count, t_addr, t_stamp);
    end
  endtask

  task automatic test_clr_drop();
    do_reset();
    for (int i = 0; i < 19; i++) begin
      WrEn   = 1'b1;
      WrAddr = 15'(16'h0200 + i);
      WrData = 16'(i);
      tick();
    end
    checks++;
    if ({Overflow, DropCnt} !== {1'b1, 8'd3}) begin
      errors++;
      $display("FAIL drop_three: got ovf=%b drop=%0d expected ovf=1 drop=3", Overflow, DropCnt);
    end
    ClrOvf = 1'b1;
    tick();
    WrEn = 1'b0;
    checks++;
    if ({Overflow, DropCnt, Count} !== {1'b1, 8'd1, 5'd16}) begin
      errors++;
      $display("FAIL clr_with_drop: got ovf=%b drop=%0d c=%0d expected ovf=1 drop=1 c=16",
               Overflow, DropCnt, Count);
    end
    tick();
    ClrOvf = 1'b0;
    checks++;
    if ({Overflow, DropCnt} !== {1'b0, 8'd0}) begin
      errors++;
      $display("FAIL clr_alone: got ovf=%b drop=%0d expected ovf=0 drop=0", Overflow, DropCnt);
    end
    OutReady = 1'b1;
    tick();
    tick();
    checks++;
    if ({Count, OutAddr} !== {5'd14, 15'h0202}) begin
      errors++;
      $display("FAIL mid_drain: got c=%0d a=%h expected c=14 a=0202", Count, OutAddr);
    end
    Reset = 1'b0;
    tick();
    Reset = 1'b1;
    checks++;
    if (dut_view !== 62'd0) begin
      errors++;
      $display("FAIL reset_mid_drain: got %h expected %h", dut_view, 62'd0);
    end
    tick();
    OutReady = 1'b0;
    checks++;
    if (dut_view !== 62'd0) begin
      errors++;
      $display("FAIL after_reset_idle: got %h expected %h", dut_view, 62'd0);
    end
  endtask

  task automatic test_random();
    int ready_pct;
    do_reset();
    for (int cyc = 0; cyc < 1500; cyc++) begin
      ready_pct = ((cyc / 250) % 2 == 0) ? 20 : 80;
      CaptureEn = ($urandom_range(99) < 90);
      WrEn      = ($urandom_range(99) < 60);
      WrAddr    = 15'($urandom);
      WrData    = 16'($urandom);
      OutReady  = ($urandom_range(99) < ready_pct);
      ClrOvf    = ($urandom_range(99) < 3);
      Reset     = ($urandom_range(999) >= 4);
      tick();
      checks++;
      if (dut_view !== model_view()) begin
        errors++;
        $display("FAIL random[%0d]: got %h expected %h", cyc, dut_view, model_view());
      end
    end
    Reset = 1'b1;
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    Reset = 1'b0;
    @(negedge Clk);
    test_reset();
    test_first_write();
    test_overflow();
    test_full_push_pop();
    test_filter();
    test_ts_wrap();
    test_clr_drop();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
